// File: rtl/i2c_shift_engine.sv
// Load/shift engine for the I2C datapath: parallel load, serial shift in/out on
// bit-timing strobes, with bit counting, auto-completion, order select and abort.
module i2c_shift_engine #(
    parameter int LENGTH      = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   CLOCK,
    input  logic                   Reset,
    input  logic                   Load,
    input  logic [LENGTH-1:0]      SentData,
    input  logic                   LsbFirst,
    input  logic                   ShiftEn,
    input  logic                   ShiftIn,
    input  logic                   Abort,
    output logic                   ShiftOut,
    output logic [LENGTH-1:0]      ReceivedData,
    output logic [COUNT_WIDTH-1:0] BitCount,
    output logic                   Busy,
    output logic                   Done
);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(LENGTH - 1);

    state_t                   r_state, w_state_nxt;
    logic [LENGTH-1:0]        r_shreg, w_shreg_nxt;
    logic [COUNT_WIDTH-1:0]   r_count, w_count_nxt;
    logic                     r_lsb,   w_lsb_nxt;
    logic                     r_done,  w_done_nxt;

    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_count <= '0;
            r_lsb   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_count <= w_count_nxt;
            r_lsb   <= w_lsb_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Abort outranks Load, so an aborting cycle never reloads.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_count_nxt = r_count;
        w_lsb_nxt   = r_lsb;
        w_done_nxt  = 1'b0;
        if (Abort) begin
            w_state_nxt = S_IDLE;
        end else if (Load) begin
            w_shreg_nxt = SentData;
            w_lsb_nxt   = LsbFirst;
            w_count_nxt = '0;
            w_state_nxt = S_SHIFT;
        end else if (r_state == S_SHIFT && ShiftEn) begin
            if (r_lsb)
                w_shreg_nxt = {ShiftIn, r_shreg[LENGTH-1:1]};
            else
                w_shreg_nxt = {r_shreg[LENGTH-2:0], ShiftIn};
            w_count_nxt = r_count + COUNT_WIDTH'(1);
            if (r_count == LAST_CNT) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    assign ShiftOut     = r_lsb ? r_shreg[0] : r_shreg[LENGTH-1];
    assign ReceivedData = r_shreg;
    assign BitCount     = r_count;
    assign Busy         = (r_state == S_SHIFT);
    assign Done         = r_done;

endmodule

// File: tb/tb_i2c_shift_engine.sv
// Directed bench for i2c_shift_engine (8-bit and 9-bit instances) with a
// scoreboard of expected serial-out bits and final received words.
module tb_i2c_shift_engine;

    logic       clk = 1'b0;
    logic       rst_n, load, lsb, sen, sin, abort;
    logic [7:0] sd8;
    logic [8:0] sd9;
    logic       so8, so9, busy8, busy9, done8, done9;
    logic [7:0] rd8;
    logic [8:0] rd9;
    logic [3:0] bc8, bc9;

    int checks = 0;
    int errors = 0;

    logic       sb_bit[$];
    logic [8:0] sb_word[$];

    always #5 clk = ~clk;

    i2c_shift_engine #(.LENGTH(8), .COUNT_WIDTH(4)) dut8 (
        .CLOCK(clk), .Reset(rst_n), .Load(load), .SentData(sd8), .LsbFirst(lsb),
        .ShiftEn(sen), .ShiftIn(sin), .Abort(abort), .ShiftOut(so8),
        .ReceivedData(rd8), .BitCount(bc8), .Busy(busy8), .Done(done8));

    i2c_shift_engine #(.LENGTH(9), .COUNT_WIDTH(4)) dut9 (
        .CLOCK(clk), .Reset(rst_n), .Load(load), .SentData(sd9), .LsbFirst(lsb),
        .ShiftEn(sen), .ShiftIn(sin), .Abort(abort), .ShiftOut(so9),
        .ReceivedData(rd9), .BitCount(bc9), .Busy(busy9), .Done(done9));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer: pat[i] is the ShiftIn value for strobe i,
    // gap is the number of idle cycles between strobes.
    task automatic xfer(input string tag, input bit use9, input logic [8:0] data,
                        input bit lsb_i, input logic [8:0] pat, input int gap,
                        input logic [8:0] exp_final);
        int len;
        logic eb;
        len = use9 ? 9 : 8;
        for (int i = 0; i < len; i++)
            sb_bit.push_back(lsb_i ? data[i] : data[len-1-i]);
        sb_word.push_back(exp_final);
        load = 1'b1; sd8 = data[7:0]; sd9 = data; lsb = lsb_i; sen = 1'b1;
        tick();
        load = 1'b0; sen = 1'b0;
        chk({tag, "_busy_load"}, use9 ? busy9 : busy8, 1);
        chk({tag, "_cnt_load"}, use9 ? bc9 : bc8, 0);
        for (int i = 0; i < len; i++) begin
            eb = sb_bit.pop_front();
            chk($sformatf("%s_so%0d", tag, i), use9 ? so9 : so8, eb);
            sen = 1'b1; sin = pat[i];
            tick();
            sen = 1'b0;
            chk($sformatf("%s_cnt%0d", tag, i), use9 ? bc9 : bc8, 16'(i + 1));
            if (i < len - 1) begin
                chk($sformatf("%s_busy%0d", tag, i), use9 ? busy9 : busy8, 1);
                chk($sformatf("%s_done%0d", tag, i), use9 ? done9 : done8, 0);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk($sformatf("%s_gapcnt%0d", tag, i), use9 ? bc9 : bc8, 16'(i + 1));
                end
            end
        end
        chk({tag, "_done_pulse"}, use9 ? done9 : done8, 1);
        chk({tag, "_busy_end"}, use9 ? busy9 : busy8, 0);
        chk({tag, "_rd"}, use9 ? rd9 : {1'b0, rd8}, sb_word.pop_front());
        tick();
        chk({tag, "_done_clr"}, use9 ? done9 : done8, 0);
        chk({tag, "_cnt_hold"}, use9 ? bc9 : bc8, 16'(len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [8:0] pat;
        rst_n = 1'b0; load = 1'b1; sen = 1'b1; sin = 1'b1; abort = 1'b0;
        lsb = 1'b1; sd8 = 8'hFF; sd9 = 9'h1FF;

        // 1: reset dominates load/shift
        tick(); tick();
        chk("rst_rd", rd8, 0);
        chk("rst_cnt", bc8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_so", so8, 0);
        chk("rst_rd9", rd9, 0);
        rst_n = 1'b1; load = 1'b0; sen = 1'b0; sin = 1'b0; lsb = 1'b0;
        tick();

        // 2: MSB-first, back-to-back strobes
        v = 8'h3C;
        pat = '0;
        for (int i = 0; i < 8; i++) pat[i] = v[7-i];
        xfer("msb", 1'b0, 9'h0A5, 1'b0, pat, 0, 9'h03C);

        // 3: LSB-first
        xfer("lsb", 1'b0, 9'h00F, 1'b1, 9'h086, 0, 9'h086);

        // 4: strobe every 5 cycles, then strobes while idle
        xfer("gap", 1'b0, 9'h0A5, 1'b0, pat, 4, 9'h03C);
        for (int i = 0; i < 3; i++) begin
            sen = 1'b1; sin = 1'b1;
            tick();
            sen = 1'b0;
            tick();
        end
        chk("idle_rd", rd8, 8'h3C);
        chk("idle_cnt", bc8, 8);
        chk("idle_busy", busy8, 0);

        // 5a: abort after 3 strobes
        load = 1'b1; sd8 = 8'hA5; lsb = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sen = 1'b1; sin = 1'b1;
            tick();
        end
        sen = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_cnt", bc8, 3);
        chk("abort_rd", rd8, 8'h2F);
        tick();
        chk("abort_done2", done8, 0);

        // 5b: load with strobe mid-transfer reloads without shifting
        load = 1'b1; sd8 = 8'h5A;
        tick();
        load = 1'b0;
        sen = 1'b1; sin = 1'b0;
        tick(); tick();
        load = 1'b1; sd8 = 8'hC3; sin = 1'b1;
        tick();
        load = 1'b0; sen = 1'b0;
        chk("reload_rd", rd8, 8'hC3);
        chk("reload_cnt", bc8, 0);
        chk("reload_busy", busy8, 1);
        chk("reload_done", done8, 0);

        // 5c: abort beats load in the same cycle
        sen = 1'b1; sin = 1'b0;
        tick(); tick();
        sen = 1'b0; abort = 1'b1; load = 1'b1; sd8 = 8'hFF;
        tick();
        abort = 1'b0; load = 1'b0;
        chk("abld_busy", busy8, 0);
        chk("abld_rd", rd8, 8'h0C);
        chk("abld_cnt", bc8, 2);
        tick();
        chk("abld_done", done8, 0);

        // 6: 9-bit instance, MSB-first
        xfer("w9", 1'b1, 9'h1A5, 1'b0, 9'h1FF, 0, 9'h1FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_shift_engine.md
Name: i2c_shift_engine

Overview:
Parametrised successor of the team's I2C shift register, used in the I2C controller datapath. It loads a byte or word and shifts it out while shifting serial data in, on single-cycle strobes from the bit-timing logic. New relative to the plain shift register:
- internal bit counter with automatic completion;
- selectable MSB-first or LSB-first order;
- Busy/Done status outputs;
- abort.

Parameters:
LENGTH, 8, shift register and data width in bits; must be >= 2.
COUNT_WIDTH, 4, width of BitCount; must satisfy 2^COUNT_WIDTH > LENGTH.

Ports:
CLOCK  input  1  sole clock; everything updates on its rising edge.
Reset  input  1  synchronous, active-low reset (0 = reset).
Load  input  1  parallel load of SentData and start of a transfer.
SentData  input  LENGTH  data to transmit; sampled when Load is accepted.
LsbFirst  input  1  order select; 0 = MSB-first, 1 = LSB-first; latched when Load is accepted.
ShiftEn  input  1  one-cycle strobe; one shift per strobe.
ShiftIn  input  1  serial input bit; sampled on cycles where ShiftEn=1.
Abort  input  1  terminates the current transfer.
ShiftOut  output  1  serial output bit.
ReceivedData  output  LENGTH  current shift register contents.
BitCount  output  COUNT_WIDTH  number of shifts done in the current or last transfer.
Busy  output  1  high while in SHIFT.
Done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE and SHIFT. Busy=1 exactly when in SHIFT.
- Priority on every edge: Reset > Abort > Load > ShiftEn.
- Reset (Reset=0 at posedge): shift register=0, BitCount=0, latched mode=0 (MSB-first), state=IDLE, Busy=0, Done=0. All other inputs are ignored that cycle.
- Load=1, in either state:
  - shift register<=SentData, mode<=LsbFirst, BitCount<=0, state<=SHIFT.
  - No shift that cycle, even if ShiftEn=1.
  - Load during SHIFT restarts the transfer; no Done for the abandoned transfer.
- SHIFT with ShiftEn=1, no Abort, no Load:
  - MSB-first: reg<={reg[LENGTH-2:0],ShiftIn}.
  - LSB-first: reg<={ShiftIn,reg[LENGTH-1:1]}.
  - BitCount<=BitCount+1.
- SHIFT with ShiftEn=0: register and count hold.
- Completion:
  - On the strobe that takes BitCount to LENGTH, state<=IDLE and Done<=1 at the same edge.
  - Result: Busy falls and Done is high for exactly the one cycle after the final strobe.
  - Done is cleared on the next edge unconditionally.
  - BitCount holds LENGTH until the next Load or Reset.
- Abort=1 in SHIFT:
  - state<=IDLE; Done stays 0.
  - Register and BitCount hold their partial values.
  - Abort in IDLE has no effect.
- IDLE: ShiftEn is ignored; register, count and mode hold.
- ShiftOut is combinational from registered state only: reg[LENGTH-1] if mode=0, reg[0] if mode=1. It is valid in every cycle, including IDLE.
- ReceivedData=reg at all times.
  - MSB-first: the first received bit ends at bit LENGTH-1.
  - LSB-first: the first received bit ends at bit 0.
- Load in the Done cycle: accepted normally; Done still pulses that cycle.
- Latency: first ShiftOut bit is valid the cycle after Load. Each shift is visible the cycle after its strobe.

Test Plan:
1. Reset: hold Reset=0 for 2 cycles with Load=1, ShiftEn=1 and SentData=0xFF -> ReceivedData=0x00, BitCount=0, Busy=0, Done=0, ShiftOut=0.
2. MSB-first: Load SentData=0xA5 with LsbFirst=0, then 8 back-to-back strobes with ShiftIn following 0x3C MSB-first -> ShiftOut=1,0,1,0,0,1,0,1; final ReceivedData=0x3C; BitCount=8; Busy falls and Done=1 for exactly one cycle after the 8th strobe.
3. LSB-first: Load 0x0F with LsbFirst=1, then 8 strobes with ShiftIn=0,1,1,0,0,0,0,1 -> ShiftOut=1,1,1,1,0,0,0,0; ReceivedData=0x86; single Done pulse.
4. Strobe gaps and IDLE: strobes every 5 cycles -> same results as scenario 2, with BitCount advancing only on strobes. ShiftEn pulses in IDLE -> ReceivedData and BitCount unchanged.
5. Abort and conflicts:
   - Abort after 3 strobes -> Busy=0 next cycle, Done never asserts, BitCount=3.
   - Load with ShiftEn in the same cycle mid-transfer -> reload, BitCount=0, no shift.
   - Abort with Load in the same cycle -> IDLE, no reload.
6. Width: LENGTH=9, COUNT_WIDTH=4, Load 9'h1A5, MSB-first, 9 strobes with ShiftIn=1 -> ShiftOut=1,1,0,1,0,0,1,0,1; ReceivedData=9'h1FF; Done one cycle after the 9th strobe; BitCount=9.
